// File: rtl/if1_fetch_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : if1_fetch_ctrl                                             |
// | Description : Fetch stage 1. Generates the PC, issues instruction-SRAM   |
// |               requests (valid/ready) and keeps up to MAX_OUTST fetches   |
// |               in an in-order entry queue. Each returned instruction is   |
// |               paired with its PC and presented to IF2 (valid/ready).     |
// |               A branch redirect flushes the queue and discards the       |
// |               responses still owed for the flushed requests.             |
// | Ports       : clk, rst            clock, synchronous active-high reset   |
// |               stall               hold PC, suppress new requests         |
// |               br_bus[32:0]        {br_e, br_addr}                        |
// |               inst_req_*          fetch request (valid/ready/addr)       |
// |               inst_rsp_*          in-order fetch response (valid/data)   |
// |               out_*               {pc, inst} to IF2 (valid/ready)        |
// |               exc_valid, exc_pc   misaligned-target exception (optional) |
// | Options     : define IF1_MISALIGN_EN to enable the misaligned-target     |
// |               exception and the exc_* ports.                             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module if1_fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h8000_0000,
  parameter int          PC_STEP   = 4,
  parameter int          MAX_OUTST = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [32:0] br_bus,
  output logic        inst_req_valid,
  input  logic        inst_req_ready,
  output logic [31:0] inst_req_addr,
  input  logic        inst_rsp_valid,
  input  logic [31:0] inst_rsp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst
`ifdef IF1_MISALIGN_EN
  ,
  output logic        exc_valid,
  output logic [31:0] exc_pc
`endif
);

  localparam int PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int CW = $clog2(MAX_OUTST + 1);
  // Responses still owed for flushed requests can pile up across repeated
  // redirects while the SRAM is slow, so the drop counter is kept wide.
  localparam int DW = 16;

  logic          br_e;
  logic [31:0]   br_addr;
  logic          halted;

  logic [31:0]   pc_q, pc_d;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d, fill_q, fill_d;
  logic [CW-1:0] count_q, count_d, unfilled_q, unfilled_d;
  logic [DW-1:0] drop_q, drop_d;

  logic [31:0]          qpc_q   [MAX_OUTST];
  logic [31:0]          qinst_q [MAX_OUTST];
  logic [MAX_OUTST-1:0] filled_q;

  logic queue_full, fire, pop, rsp_fill, rsp_drop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTST - 1)) ? '0 : p + PW'(1);
  endfunction

  assign br_e    = br_bus[32];
  assign br_addr = br_bus[31:0];

  assign queue_full     = (count_q == CW'(MAX_OUTST));
  assign inst_req_valid = !rst && !stall && !br_e && !queue_full && !halted;
  assign inst_req_addr  = pc_q;
  assign fire           = inst_req_valid && inst_req_ready;

  // A response belongs to a flushed request while drop_q is non-zero;
  // otherwise it fills the oldest unfilled entry. A response with neither
  // (e.g. one owed from before reset) is ignored.
  assign rsp_drop = inst_rsp_valid && (drop_q != '0);
  assign rsp_fill = inst_rsp_valid && (drop_q == '0) && (unfilled_q != '0);

  assign out_valid = filled_q[head_q];
  assign out_pc    = qpc_q[head_q];
  assign out_inst  = qinst_q[head_q];
  // The flush wins over a same-cycle pop.
  assign pop       = out_valid && out_ready && !br_e;

  always_comb begin
    pc_d       = pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    fill_d     = fill_q;
    count_d    = count_q;
    unfilled_d = unfilled_q;
    drop_d     = drop_q;
    if (br_e) begin
      pc_d       = br_addr;
      head_d     = '0;
      tail_d     = '0;
      fill_d     = '0;
      count_d    = '0;
      unfilled_d = '0;
      // Every allocated-but-unfilled entry still owes a response, except
      // the one being filled right now.
      drop_d     = DW'(unfilled_q) - DW'(rsp_fill) + drop_q - DW'(rsp_drop);
    end else begin
      if (fire) begin
        pc_d   = pc_q + 32'(PC_STEP);
        tail_d = ptr_inc(tail_q);
      end
      if (pop)      head_d = ptr_inc(head_q);
      if (rsp_fill) fill_d = ptr_inc(fill_q);
      count_d    = count_q + CW'(fire) - CW'(pop);
      unfilled_d = unfilled_q + CW'(fire) - CW'(rsp_fill);
      drop_d     = drop_q - DW'(rsp_drop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      head_q     <= '0;
      tail_q     <= '0;
      fill_q     <= '0;
      count_q    <= '0;
      unfilled_q <= '0;
      drop_q     <= '0;
    end else begin
      pc_q       <= pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      fill_q     <= fill_d;
      count_q    <= count_d;
      unfilled_q <= unfilled_d;
      drop_q     <= drop_d;
    end
  end

  // Entry storage. Tail, fill and head slots never coincide in one cycle:
  // tail is free, fill is allocated-unfilled and head is filled.
  always_ff @(posedge clk) begin
    if (rst || br_e) begin
      filled_q <= '0;
    end else begin
      if (fire) begin
        qpc_q[tail_q]    <= pc_q;
        filled_q[tail_q] <= 1'b0;
      end
      if (rsp_fill) begin
        qinst_q[fill_q]  <= inst_rsp_data;
        filled_q[fill_q] <= 1'b1;
      end
      if (pop) filled_q[head_q] <= 1'b0;
    end
  end

`ifdef IF1_MISALIGN_EN
  logic        halted_q, halted_d;
  logic [31:0] exc_pc_q, exc_pc_d;

  always_comb begin
    halted_d = halted_q;
    exc_pc_d = exc_pc_q;
    if (br_e) begin
      halted_d = (br_addr[1:0] != 2'b00);
      if (br_addr[1:0] != 2'b00) exc_pc_d = br_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      halted_q <= 1'b0;
      exc_pc_q <= '0;
    end else begin
      halted_q <= halted_d;
      exc_pc_q <= exc_pc_d;
    end
  end

  assign halted    = halted_q;
  assign exc_valid = halted_q;
  assign exc_pc    = exc_pc_q;
`else
  assign halted = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_if1_fetch_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_if1_fetch_ctrl                                          |
// | Description : Self-checking bench for if1_fetch_ctrl. An SRAM model      |
// |               answers accepted requests in order with data derived from  |
// |               the address; a scoreboard of expected PCs (own PC model)   |
// |               is checked at every IF2 handshake.                         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_if1_fetch_ctrl;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst, stall;
  logic [32:0] br_bus;
  logic        inst_req_valid, inst_req_ready;
  logic [31:0] inst_req_addr;
  logic        inst_rsp_valid;
  logic [31:0] inst_rsp_data;
  logic        out_valid, out_ready;
  logic [31:0] out_pc, out_inst;
`ifdef IF1_MISALIGN_EN
  logic        exc_valid;
  logic [31:0] exc_pc;
`endif

  if1_fetch_ctrl #(.RESET_PC(RESET_PC), .PC_STEP(4), .MAX_OUTST(2)) dut (
    .clk(clk), .rst(rst), .stall(stall), .br_bus(br_bus),
    .inst_req_valid(inst_req_valid), .inst_req_ready(inst_req_ready),
    .inst_req_addr(inst_req_addr),
    .inst_rsp_valid(inst_rsp_valid), .inst_rsp_data(inst_rsp_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst)
`ifdef IF1_MISALIGN_EN
    , .exc_valid(exc_valid), .exc_pc(exc_pc)
`endif
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_fires  = 0;
  int          n_pops   = 0;
  logic        rsp_en;
  logic [31:0] model_pc;
  logic [31:0] last_pop_pc;
  logic [31:0] last_fire_addr;
  logic [31:0] exp_q[$];   // scoreboard: PCs expected at IF2, in order
  logic [31:0] pend_q[$];  // SRAM: accepted addresses still owed a response

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_1234;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: sample 1 time unit after the inputs were driven on the
  // falling edge, update models, then drive the SRAM response for the next
  // cycle on the following falling edge.
  task automatic tick();
    logic f, p, b;
    #1;
    b = br_bus[32];
    f = inst_req_valid && inst_req_ready;
    p = out_valid && out_ready;
    if (rst) begin
      exp_q.delete();
      model_pc = RESET_PC;
    end else if (b) begin
      exp_q.delete();
      model_pc = br_bus[31:0];
    end else if (p) begin
      n_pops++;
      last_pop_pc = out_pc;
      if (exp_q.size() == 0) begin
        check("unexpected_pop", out_pc, 32'hxxxx_xxxx);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check("pop_pc", out_pc, e);
        check("pop_inst", out_inst, mem_word(e));
      end
    end
    if (f) begin
      check("req_addr", inst_req_addr, model_pc);
      pend_q.push_back(inst_req_addr);
      exp_q.push_back(model_pc);
      last_fire_addr = inst_req_addr;
      model_pc = model_pc + 32'd4;
      n_fires++;
    end
    @(posedge clk);
    @(negedge clk);
    if (rsp_en && pend_q.size() > 0) begin
      inst_rsp_valid = 1'b1;
      inst_rsp_data  = mem_word(pend_q.pop_front());
    end else begin
      inst_rsp_valid = 1'b0;
      inst_rsp_data  = '0;
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Wait (bounded) for the next IF2 handshake and check its PC.
  task automatic expect_pop(input string tag, input logic [31:0] exp, input int max);
    int n0;
    n0 = n_pops;
    last_pop_pc = 32'hxxxx_xxxx;
    for (int i = 0; i < max && n_pops == n0; i++) tick();
    check(tag, last_pop_pc, exp);
  endtask

  task automatic redirect(input logic [31:0] a);
    br_bus = {1'b1, a};
    tick();
    br_bus = '0;
  endtask

  initial begin
    int f0;
    logic [31:0] held;
    rst = 1'b1; stall = 1'b0; br_bus = '0; inst_req_ready = 1'b1;
    inst_rsp_valid = 1'b0; inst_rsp_data = '0; out_ready = 1'b0; rsp_en = 1'b1;
    model_pc = RESET_PC;
    @(negedge clk);
    ticks(2);
    check("rst_req_valid", {31'd0, inst_req_valid}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
`ifdef IF1_MISALIGN_EN
    check("rst_exc_valid", {31'd0, exc_valid}, 32'd0);
`endif

    // Back-pressure from IF2: exactly MAX_OUTST requests, then issue stops.
    rst = 1'b0;
    check("reset_pc", inst_req_addr, RESET_PC);
    f0 = n_fires;
    ticks(6);
    check("bp_fires", n_fires - f0, 32'd2);
    check("bp_req_valid", {31'd0, inst_req_valid}, 32'd0);
    out_ready = 1'b1;
    expect_pop("bp_first_pop", RESET_PC, 4);
    ticks(12);

    // Stall: no issue, PC held, queued fetches still drain.
    stall = 1'b1;
    held = inst_req_addr;
    f0 = n_fires;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_req_valid", {31'd0, inst_req_valid}, 32'd0);
      check("stall_pc_held", inst_req_addr, held);
    end
    check("stall_fires", n_fires - f0, 32'd0);
    check("stall_drained", {31'd0, out_valid}, 32'd0);
    stall = 1'b0;
    tick();
    check("stall_resume", last_fire_addr, held);
    ticks(6);

    // Redirect with two fetches in flight: both responses discarded.
    rsp_en = 1'b0;
    ticks(4);
    check("inflight_two", pend_q.size(), 32'd2);
    redirect(32'h0000_1000);
    rsp_en = 1'b1;
    tick();
    check("flush_out_valid", {31'd0, out_valid}, 32'd0);
    expect_pop("redir_first_pop", 32'h0000_1000, 8);
    ticks(6);

    // Response in the redirect cycle with one more outstanding: one drop.
    rsp_en = 1'b0;
    ticks(4);
    rsp_en = 1'b1;
    tick();
    redirect(32'h0000_3000);
    expect_pop("rsp_redir_pop", 32'h0000_3000, 8);
    expect_pop("rsp_redir_pop2", 32'h0000_3004, 8);

    // Back-to-back redirects: last wins.
    br_bus = {1'b1, 32'h0000_5000};
    tick();
    redirect(32'h0000_6000);
    expect_pop("b2b_redir_pop", 32'h0000_6000, 8);

    // PC wrap-around.
    redirect(32'hFFFF_FFF8);
    expect_pop("wrap_pop0", 32'hFFFF_FFF8, 8);
    expect_pop("wrap_pop1", 32'hFFFF_FFFC, 8);
    expect_pop("wrap_pop2", 32'h0000_0000, 8);

    // Reset mid-transaction: owed responses arrive later and are ignored.
    rsp_en = 1'b0;
    ticks(4);
    rst = 1'b1;
    ticks(2);
    rst = 1'b0; stall = 1'b1; rsp_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
    end
    stall = 1'b0;
    expect_pop("post_rst_pop", RESET_PC, 8);
    ticks(4);

`ifdef IF1_MISALIGN_EN
    redirect(32'h0000_1002);
    check("exc_valid_set", {31'd0, exc_valid}, 32'd1);
    check("exc_pc", exc_pc, 32'h0000_1002);
    f0 = n_fires;
    ticks(3);
    check("exc_no_issue", n_fires - f0, 32'd0);
    redirect(32'h0000_2000);
    check("exc_valid_clr", {31'd0, exc_valid}, 32'd0);
    expect_pop("exc_resume_pop", 32'h0000_2000, 8);
`endif

    ticks(4);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
